// File: rtl/raster_pkg.sv
// Shared constants, types and the edge vertex table for the raster setup scheduler.
package raster_pkg;

  localparam int unsigned COORD_W   = 11;
  localparam int unsigned EDGE_W    = 20;
  localparam int unsigned BAR_W     = 22;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned V_TOTAL   = 525;
  localparam int unsigned H_LAST    = 799;
  localparam int unsigned N_EDGES   = 6;
  localparam int unsigned MAC_STEPS = 12;

  typedef enum logic [1:0] {StIdle, StSetup, StLoad} state_e;

  // Edges 0..2 belong to t1, 3..5 to t2; entry i holds vertex a / b of edge i.
  localparam logic [N_EDGES-1:0][1:0] EDGE_VA = {2'd3, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0};
  localparam logic [N_EDGES-1:0][1:0] EDGE_VB = {2'd0, 2'd3, 2'd2, 2'd0, 2'd2, 2'd1};

  // Bar index order: 0 bar_iy, 1 bar_iz, 2 bar2_iy, 3 bar2_iz.
  typedef struct packed {
    logic [3:0][COORD_W-1:0] vx;
    logic [3:0][COORD_W-1:0] vy;
    logic [3:0][BAR_W-1:0]   bar_init;
    logic [3:0][BAR_W-1:0]   bar_dy;
    logic [3:0][BAR_W-1:0]   bar_dx;
  } param_set_t;

  function automatic logic [COORD_W:0] sext_c(input logic [COORD_W-1:0] v);
    return {v[COORD_W-1], v};
  endfunction

endpackage

// File: rtl/edge_setup_mac.sv
// Shared-multiplier accumulator computing the six line-0 edge values over 12 cycles.
module edge_setup_mac
  import raster_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [3:0][COORD_W-1:0]          vx,
  input  logic [3:0][COORD_W-1:0]          vy,
  output logic                             done,
  output logic [N_EDGES-1:0][EDGE_W-1:0]   e_line0
);

  localparam int unsigned ACC_W  = EDGE_W + 4;
  localparam int unsigned PROD_W = 2 * COORD_W + 1;

  logic              busy_q;
  logic [3:0]        k_q;
  logic [2:0]        edge_idx;
  logic [1:0]        va, vb;
  logic [COORD_W:0]  op_diff;
  logic [COORD_W-1:0] op_coord;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc_q, sum;

  always_comb begin
    edge_idx = k_q[3:1];
    va       = EDGE_VA[edge_idx];
    vb       = EDGE_VB[edge_idx];
    // Even k: -xa*(yb-ya) as xa*(ya-yb); odd k: ya*(xb-xa).
    if (!k_q[0]) begin
      op_diff  = sext_c(vy[va]) - sext_c(vy[vb]);
      op_coord = vx[va];
    end else begin
      op_diff  = sext_c(vx[vb]) - sext_c(vx[va]);
      op_coord = vy[va];
    end
    prod = {{(PROD_W-COORD_W-1){op_diff[COORD_W]}}, op_diff}
         * {{(PROD_W-COORD_W){op_coord[COORD_W-1]}}, op_coord};
    sum  = (k_q[0] ? acc_q : '0) + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    done = busy_q && (k_q == 4'(MAC_STEPS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      k_q     <= '0;
      acc_q   <= '0;
      e_line0 <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      k_q    <= '0;
    end else if (busy_q) begin
      acc_q <= sum;
      if (k_q[0]) e_line0[edge_idx] <= sum[EDGE_W-1:0];
      if (done) begin
        busy_q <= 1'b0;
        k_q    <= '0;
      end else begin
        k_q <= k_q + 4'd1;
      end
    end
  end

endmodule

// File: rtl/raster_setup_sched.sv
// Frame/line scheduler: shadow-buffers VS parameters, sets up line-0 edges, steps per line.
module raster_setup_sched
  import raster_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               param_valid,
  output logic               param_ready,
  input  logic [COORD_W-1:0] vx0, vx1, vx2, vx3,
  input  logic [COORD_W-1:0] vy0, vy1, vy2, vy3,
  input  logic [BAR_W-1:0]   bar_iy_in, bar_iz_in, bar2_iy_in, bar2_iz_in,
  input  logic [BAR_W-1:0]   bar_iy_dy, bar_iz_dy, bar2_iy_dy, bar2_iz_dy,
  input  logic [BAR_W-1:0]   bar_iy_dx, bar_iz_dx, bar2_iy_dx, bar2_iz_dx,
  output logic [EDGE_W-1:0]  y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3,
  output logic [EDGE_W-1:0]  e0_init_t1, e1_init_t1, e2_init_t1,
  output logic [EDGE_W-1:0]  e0_init_t2, e1_init_t2, e2_init_t2,
  output logic [BAR_W-1:0]   bar_iy, bar_iz, bar2_iy, bar2_iz,
  output logic [BAR_W-1:0]   bar_iy_dx_o, bar_iz_dx_o, bar2_iy_dx_o, bar2_iz_dx_o,
  output logic               frame_commit
);

  state_e                          state_q, state_d;
  param_set_t                      shadow_q, active_q, vs_in;
  logic                            shadow_full_q, frame_commit_q;
  logic [N_EDGES-1:0][EDGE_W-1:0]  e_q, e_line0, step;
  logic [N_EDGES-1:0][COORD_W:0]   diff;
  logic [3:0][BAR_W-1:0]           bar_q;
  logic                            commit, line_step, mac_start, mac_done;

  assign commit    = (x == 10'd0) && (y == 10'(V_ACTIVE));
  assign line_step = (state_q == StIdle) && (x == 10'd0) && (y < 10'(V_ACTIVE - 1)) && !commit;

  always_comb begin
    vs_in.vx       = {vx3, vx2, vx1, vx0};
    vs_in.vy       = {vy3, vy2, vy1, vy0};
    vs_in.bar_init = {bar2_iz_in, bar2_iy_in, bar_iz_in, bar_iy_in};
    vs_in.bar_dy   = {bar2_iz_dy, bar2_iy_dy, bar_iz_dy, bar_iy_dy};
    vs_in.bar_dx   = {bar2_iz_dx, bar2_iy_dx, bar_iz_dx, bar_iy_dx};
  end

  // Per-line edge step is xa - xb of the active set.
  always_comb begin
    for (int i = 0; i < N_EDGES; i++) begin
      diff[i] = sext_c(active_q.vx[EDGE_VA[i]]) - sext_c(active_q.vx[EDGE_VB[i]]);
      step[i] = {{(EDGE_W-COORD_W-1){diff[i][COORD_W]}}, diff[i]};
    end
  end

  always_comb begin
    state_d   = state_q;
    mac_start = 1'b0;
    if (commit) begin
      state_d   = StSetup;
      mac_start = 1'b1;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StSetup: if (mac_done) state_d = StLoad;
        StLoad:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  edge_setup_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mac_start),
    .vx      (active_q.vx),
    .vy      (active_q.vy),
    .done    (mac_done),
    .e_line0 (e_line0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      shadow_q       <= '0;
      active_q       <= '0;
      shadow_full_q  <= 1'b0;
      frame_commit_q <= 1'b0;
      e_q            <= '0;
      bar_q          <= '0;
    end else begin
      state_q        <= state_d;
      frame_commit_q <= commit && shadow_full_q;
      if (commit && shadow_full_q) begin
        active_q      <= shadow_q;
        shadow_full_q <= 1'b0;
      end else if (param_valid && !shadow_full_q) begin
        shadow_q      <= vs_in;
        shadow_full_q <= 1'b1;
      end
      if (state_q == StLoad) begin
        e_q   <= e_line0;
        bar_q <= active_q.bar_init;
      end else if (line_step) begin
        for (int i = 0; i < N_EDGES; i++) e_q[i] <= e_q[i] + step[i];
        for (int j = 0; j < 4; j++) bar_q[j] <= bar_q[j] + active_q.bar_dy[j];
      end
    end
  end

  assign param_ready  = !shadow_full_q;
  assign frame_commit = frame_commit_q;

  assign y_screen_v0 = {{(EDGE_W-COORD_W){active_q.vy[0][COORD_W-1]}}, active_q.vy[0]};
  assign y_screen_v1 = {{(EDGE_W-COORD_W){active_q.vy[1][COORD_W-1]}}, active_q.vy[1]};
  assign y_screen_v2 = {{(EDGE_W-COORD_W){active_q.vy[2][COORD_W-1]}}, active_q.vy[2]};
  assign y_screen_v3 = {{(EDGE_W-COORD_W){active_q.vy[3][COORD_W-1]}}, active_q.vy[3]};

  assign e0_init_t1 = e_q[0];
  assign e1_init_t1 = e_q[1];
  assign e2_init_t1 = e_q[2];
  assign e0_init_t2 = e_q[3];
  assign e1_init_t2 = e_q[4];
  assign e2_init_t2 = e_q[5];

  assign bar_iy  = bar_q[0];
  assign bar_iz  = bar_q[1];
  assign bar2_iy = bar_q[2];
  assign bar2_iz = bar_q[3];

  assign bar_iy_dx_o  = active_q.bar_dx[0];
  assign bar_iz_dx_o  = active_q.bar_dx[1];
  assign bar2_iy_dx_o = active_q.bar_dx[2];
  assign bar2_iz_dx_o = active_q.bar_dx[3];

endmodule

// File: tb/tb_raster_setup_sched.sv
// Directed bench for raster_setup_sched: handshake, commit, setup latency, stepping, reset.
module tb_raster_setup_sched;
  import raster_pkg::*;

  logic               clk, rst_n, param_valid, param_ready, frame_commit;
  logic [9:0]         x, y;
  logic [COORD_W-1:0] vx0, vx1, vx2, vx3, vy0, vy1, vy2, vy3;
  logic [BAR_W-1:0]   bar_iy_in, bar_iz_in, bar2_iy_in, bar2_iz_in;
  logic [BAR_W-1:0]   bar_iy_dy, bar_iz_dy, bar2_iy_dy, bar2_iz_dy;
  logic [BAR_W-1:0]   bar_iy_dx, bar_iz_dx, bar2_iy_dx, bar2_iz_dx;
  logic [EDGE_W-1:0]  y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3;
  logic [EDGE_W-1:0]  e0_init_t1, e1_init_t1, e2_init_t1, e0_init_t2, e1_init_t2, e2_init_t2;
  logic [BAR_W-1:0]   bar_iy, bar_iz, bar2_iy, bar2_iz;
  logic [BAR_W-1:0]   bar_iy_dx_o, bar_iz_dx_o, bar2_iy_dx_o, bar2_iz_dx_o;
  logic               any_out;
  int                 checks = 0;
  int                 errors = 0;

  raster_setup_sched dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .param_valid(param_valid), .param_ready(param_ready),
    .vx0(vx0), .vx1(vx1), .vx2(vx2), .vx3(vx3),
    .vy0(vy0), .vy1(vy1), .vy2(vy2), .vy3(vy3),
    .bar_iy_in(bar_iy_in), .bar_iz_in(bar_iz_in),
    .bar2_iy_in(bar2_iy_in), .bar2_iz_in(bar2_iz_in),
    .bar_iy_dy(bar_iy_dy), .bar_iz_dy(bar_iz_dy),
    .bar2_iy_dy(bar2_iy_dy), .bar2_iz_dy(bar2_iz_dy),
    .bar_iy_dx(bar_iy_dx), .bar_iz_dx(bar_iz_dx),
    .bar2_iy_dx(bar2_iy_dx), .bar2_iz_dx(bar2_iz_dx),
    .y_screen_v0(y_screen_v0), .y_screen_v1(y_screen_v1),
    .y_screen_v2(y_screen_v2), .y_screen_v3(y_screen_v3),
    .e0_init_t1(e0_init_t1), .e1_init_t1(e1_init_t1), .e2_init_t1(e2_init_t1),
    .e0_init_t2(e0_init_t2), .e1_init_t2(e1_init_t2), .e2_init_t2(e2_init_t2),
    .bar_iy(bar_iy), .bar_iz(bar_iz), .bar2_iy(bar2_iy), .bar2_iz(bar2_iz),
    .bar_iy_dx_o(bar_iy_dx_o), .bar_iz_dx_o(bar_iz_dx_o),
    .bar2_iy_dx_o(bar2_iy_dx_o), .bar2_iz_dx_o(bar2_iz_dx_o),
    .frame_commit(frame_commit)
  );

  assign any_out = |{y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3,
                     e0_init_t1, e1_init_t1, e2_init_t1, e0_init_t2, e1_init_t2, e2_init_t2,
                     bar_iy, bar_iz, bar2_iy, bar2_iz,
                     bar_iy_dx_o, bar_iz_dx_o, bar2_iy_dx_o, bar2_iz_dx_o, frame_commit};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_e(input string tag, input logic [EDGE_W-1:0] obs, input int exp);
    logic [EDGE_W-1:0] e;
    e = exp[EDGE_W-1:0];
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(e));
    end
  endtask

  task automatic set_verts(input int ax0, ay0, ax1, ay1, ax2, ay2, ax3, ay3);
    vx0 = COORD_W'(ax0); vy0 = COORD_W'(ay0);
    vx1 = COORD_W'(ax1); vy1 = COORD_W'(ay1);
    vx2 = COORD_W'(ax2); vy2 = COORD_W'(ay2);
    vx3 = COORD_W'(ax3); vy3 = COORD_W'(ay3);
  endtask

  task automatic set_a();
    set_verts(100, 100, 200, 100, 100, 200, 200, 200);
    bar_iy_in = 22'h040000; bar_iz_in = 22'h001000; bar2_iy_in = '0; bar2_iz_in = 22'h3FFFFF;
    bar_iy_dy = 22'h000100; bar_iz_dy = 22'h3FFF00; bar2_iy_dy = '0; bar2_iz_dy = 22'h000001;
    bar_iy_dx = 22'h11; bar_iz_dx = 22'h22; bar2_iy_dx = 22'h33; bar2_iz_dx = 22'h44;
  endtask

  task automatic set_b();
    set_verts(10, 20, -30, 50, 40, -60, 0, 0);
    bar_iy_in = 22'h012345; bar_iz_in = '0; bar2_iy_in = '0; bar2_iz_in = '0;
    bar_iy_dy = '0; bar_iz_dy = '0; bar2_iy_dy = '0; bar2_iz_dy = '0;
    bar_iy_dx = 22'h55; bar_iz_dx = '0; bar2_iy_dx = '0; bar2_iz_dx = '0;
  endtask

  task automatic pulse_line(input int line);
    y = 10'(line);
    x = 10'd0;
    step(1);
    x = 10'd1;
  endtask

  initial begin
    rst_n = 1'b0; param_valid = 1'b0; x = 10'd5; y = 10'd100;
    set_a();
    step(3);
    chk("reset_outs_zero", 32'(any_out), 0);
    chk("reset_ready", 32'(param_ready), 1);
    rst_n = 1'b1;
    step(1);
    chk("post_reset_outs_zero", 32'(any_out), 0);

    // Accept A, then hold B with valid while the shadow is full.
    param_valid = 1'b1;
    step(1);
    chk("ready_after_a", 32'(param_ready), 0);
    set_b();
    step(3);
    chk("ready_held_low", 32'(param_ready), 0);

    pulse_line(480);
    chk("commit1_pulse", 32'(frame_commit), 1);
    chk("commit1_ready", 32'(param_ready), 1);
    step(1);
    chk("b_accepted", 32'(param_ready), 0);
    chk("commit1_pulse_once", 32'(frame_commit), 0);
    chk_e("ysv1_a", y_screen_v1, 100);
    chk("dx_a", 32'(bar_iy_dx_o), 32'h11);
    param_valid = 1'b0;
    step(11);
    chk_e("e0_t1_before_load", e0_init_t1, 0);
    step(1);
    chk_e("e0_t1_a", e0_init_t1, 10000);
    chk_e("e1_t1_a", e1_init_t1, -30000);
    chk_e("e2_t1_a", e2_init_t1, 10000);
    chk_e("e0_t2_a", e0_init_t2, -10000);
    chk_e("e1_t2_a", e1_init_t2, 20000);
    chk_e("e2_t2_a", e2_init_t2, 0);
    chk("bar_iy_load", 32'(bar_iy), 32'h40000);
    chk("bar2_iz_load", 32'(bar2_iz), 32'h3FFFFF);

    x = 10'd799;
    step(2);
    chk_e("e0_t1_vblank_hold", e0_init_t1, 10000);

    pulse_line(0);
    chk_e("e0_t1_line1", e0_init_t1, 9900);
    chk_e("e1_t1_line1", e1_init_t1, -29900);
    chk_e("e2_t1_line1", e2_init_t1, 10000);
    chk_e("e1_t2_line1", e1_init_t2, 19900);
    chk_e("e2_t2_line1", e2_init_t2, 100);
    chk("bar_iy_line1", 32'(bar_iy), 32'h40100);
    chk("bar_iz_line1", 32'(bar_iz), 32'h000F00);
    chk("bar2_iz_wrap", 32'(bar2_iz), 32'h0);
    x = 10'd799;
    step(3);
    chk_e("e0_t1_x799", e0_init_t1, 9900);
    chk("bar_iy_x799", 32'(bar_iy), 32'h40100);

    pulse_line(479);
    chk("bar_iy_y479", 32'(bar_iy), 32'h40100);
    chk_e("e0_t1_y479", e0_init_t1, 9900);
    pulse_line(500);
    pulse_line(524);
    chk("bar_iy_y524", 32'(bar_iy), 32'h40100);
    chk_e("e1_t1_y524", e1_init_t1, -29900);

    // Second frame draws B.
    pulse_line(480);
    chk("commit2_pulse", 32'(frame_commit), 1);
    chk("commit2_ready", 32'(param_ready), 1);
    step(13);
    chk_e("e0_t1_b", e0_init_t1, -1100);
    chk_e("e1_t1_b", e1_init_t1, 200);
    chk_e("e2_t1_b", e2_init_t1, -1400);
    chk_e("ysv2_b", y_screen_v2, -60);
    chk("bar_iy_b", 32'(bar_iy), 32'h12345);
    chk("dx_b", 32'(bar_iy_dx_o), 32'h55);
    pulse_line(0);
    chk_e("e0_t1_b_line1", e0_init_t1, -1060);
    chk_e("e1_t1_b_line1", e1_init_t1, 130);

    // No new set: re-setup of B, no pulse.
    pulse_line(480);
    chk("commit3_no_pulse", 32'(frame_commit), 0);
    step(1);
    chk("commit3_no_pulse_next", 32'(frame_commit), 0);
    step(12);
    chk_e("e0_t1_redraw", e0_init_t1, -1100);
    chk_e("e2_t1_redraw", e2_init_t1, -1400);

    // Reset at k=5 of setup.
    pulse_line(480);
    step(5);
    chk_e("e0_t1_pre_abort", e0_init_t1, -1100);
    rst_n = 1'b0;
    #1;
    chk("abort_outs_zero", 32'(any_out), 0);
    chk("abort_ready", 32'(param_ready), 1);
    step(2);
    rst_n = 1'b1;
    set_a();
    param_valid = 1'b1;
    step(1);
    param_valid = 1'b0;
    pulse_line(480);
    step(13);
    chk_e("e0_t1_resume", e0_init_t1, 10000);
    chk_e("ysv3_resume", y_screen_v3, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
